// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: one-deep sample hold, integer BCLK divider, MSB-first
// serial data launched on BCLK falling edges with the standard one-bit LRCK delay.
module i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bclk,
  output logic              lrck,
  output logic              sdata,
  output logic              underrun
);

  localparam int FW = 2 * DATA_W;
  localparam int SW = $clog2(FW);
  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;

  logic [CW-1:0] div_cnt;
  logic [SW-1:0] slot, slot_nxt;
  logic [FW-1:0] shreg, frame;
  pair_t         hold;
  logic          hold_full;
  logic          tick, fall, load, accept;

  assign tick     = (div_cnt == CW'(BCLK_DIV - 1));
  assign fall     = en && tick && bclk;
  assign slot_nxt = (slot == SW'(FW - 1)) ? '0 : slot + SW'(1);
  assign load     = fall && (slot_nxt == SW'(1));
  assign accept   = in_valid && !hold_full;
  assign in_ready = !hold_full;
  // An empty hold at load time sends a silent frame rather than stalling the link.
  assign frame    = hold_full ? FW'(hold) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      bclk     <= 1'b0;
      lrck     <= 1'b0;
      sdata    <= 1'b0;
      slot     <= SW'(FW - 1);
      shreg    <= '0;
      underrun <= 1'b0;
    end else if (!en) begin
      div_cnt  <= '0;
      bclk     <= 1'b0;
      lrck     <= 1'b0;
      sdata    <= 1'b0;
      slot     <= SW'(FW - 1);
      shreg    <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= load && !hold_full;
      if (tick) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
      if (fall) begin
        slot <= slot_nxt;
        lrck <= (slot_nxt >= SW'(DATA_W));
        if (load) begin
          sdata <= frame[FW-1];
          shreg <= frame << 1;
        end else begin
          sdata <= shreg[FW-1];
          shreg <= shreg << 1;
        end
      end
    end
  end

  // Hold register keeps working while the serializer is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= '{left: in_left, right: in_right};
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: timing-level model of the serial stream, a bit-level receiver
// that rebuilds frames from the DUT pins, and directed scenarios with literal frames.
module tb_i2s_tx;
  localparam int W    = 16;
  localparam int D    = 4;
  localparam int FW   = 2 * W;
  localparam int HALF = 2 * D;

  logic         clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_left = '0, in_right = '0;
  logic         in_ready, bclk, lrck, sdata, underrun;

  i2s_tx #(.DATA_W(W), .BCLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .en(en), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrck(lrck),
    .sdata(sdata), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: enabled-edge count p gives ticks = p/D, falls = p/(2D); slot = falls-1 mod FW.
  int          m_p = 0, m_slot = FW - 1, m_ticks, m_n;
  logic [FW-1:0] m_cur = '0, m_hold = '0;
  logic        m_hold_full = 1'b0, m_fall = 1'b0, m_acc, m_was_full;
  logic        e_bclk = 0, e_lrck = 0, e_sdata = 0, e_ur = 0, e_rdy = 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p = 0; m_cur = '0; m_hold = '0; m_hold_full = 0; m_fall = 0; m_slot = FW - 1;
      e_bclk = 0; e_lrck = 0; e_sdata = 0; e_ur = 0; e_rdy = 1;
    end else begin
      m_acc = in_valid && !m_hold_full;
      m_was_full = m_hold_full;
      m_fall = 0;
      e_ur = 0;
      if (!en) begin
        m_p = 0; m_cur = '0; m_slot = FW - 1;
        e_bclk = 0; e_lrck = 0; e_sdata = 0;
      end else begin
        m_p++;
        m_ticks = m_p / D;
        m_n = m_ticks / 2;
        e_bclk = (m_ticks % 2) == 1;
        m_fall = (m_p % HALF) == 0;
        if (m_n == 0) begin
          e_lrck = 0; e_sdata = 0;
        end else begin
          m_slot = (m_n - 1) % FW;
          if (m_fall && m_slot == 1) begin
            if (m_was_full) begin
              m_cur = m_hold; m_hold_full = 0;
            end else begin
              m_cur = '0; e_ur = 1;
            end
          end
          e_lrck = (m_slot >= W);
          e_sdata = (m_slot == 0) ? m_cur[0] : m_cur[FW - m_slot];
        end
      end
      if (m_acc) begin
        m_hold = {in_left, in_right};
        m_hold_full = 1;
      end
      e_rdy = !m_hold_full;
    end
  end

  // Per-cycle compare plus DUT event counters.
  logic cmp_on = 1'b0, rdy_d = 1'b1;
  int   d_ur = 0, d_acc = 0;
  always @(negedge clk) begin
    if (!rst && cmp_on) begin
      check("bclk", bclk, e_bclk);
      check("lrck", lrck, e_lrck);
      check("sdata", sdata, e_sdata);
      check("underrun", underrun, e_ur);
      check("in_ready", in_ready, e_rdy);
    end
    if (underrun === 1'b1) d_ur++;
    if (rdy_d && in_ready === 1'b0) d_acc++;
    rdy_d = in_ready;
  end

  // Receiver: sample on BCLK rise; a frame closes with the slot-0 bit after LRCK falls.
  logic [FW-1:0] rx = '0;
  logic          prev_l = 1'b0, bclk_d = 1'b0;
  logic [FW-1:0] rx_q[$];
  always @(negedge clk) begin
    if (rst) begin
      rx = '0; prev_l = 0; bclk_d = 0;
    end else begin
      if (bclk && !bclk_d) begin
        if (!lrck && prev_l) begin
          rx_q.push_back({rx[FW-2:0], sdata});
          rx = '0;
        end else begin
          rx = {rx[FW-2:0], sdata};
        end
        prev_l = lrck;
      end
      bclk_d = bclk;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fall(input int s, input string nm);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (en && m_fall && m_slot == s) break;
    end
    if (k == 1000) begin
      tests++; fails++;
      $display("FAIL timeout %s: no fall at slot %0d", nm, s);
    end
  endtask

  task automatic wait_pre_load(input string nm);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (en && ((m_p + 1) % HALF) == 0 && ((((m_p + 1) / HALF) - 1) % FW) == 1) break;
    end
    if (k == 1000) begin
      tests++; fails++;
      $display("FAIL timeout %s: no upcoming load", nm);
    end
  endtask

  function automatic logic [63:0] q0();
    return (rx_q.size() > 0) ? 64'(rx_q[0]) : 64'hdead_0000_0000_dead;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int ur0, acc0, k, nxt;
  logic last;

  initial begin
    // Reset state
    cyc(2);
    check("rst in_ready", in_ready, 1);
    check("rst bclk", bclk, 0);
    check("rst lrck", lrck, 0);
    check("rst sdata", sdata, 0);
    check("rst underrun", underrun, 0);
    rst = 0;
    cmp_on = 1;
    cyc(1);

    // Idle enable: first fall at 8 clk, one silent frame with one underrun per 256 clk
    en = 1;
    ur0 = d_ur;
    cyc(4);
    check("bclk first rise", bclk, 1);
    cyc(3);
    check("bclk high 7", bclk, 1);
    cyc(1);
    check("bclk first fall", bclk, 0);
    cyc(292);
    check("idle underruns", d_ur - ur0, 2);
    check("idle frames", rx_q.size(), 1);
    check("idle frame zero", q0(), 0);

    // Single pair ahead of the load
    rx_q.delete();
    in_left = 16'hA5F0; in_right = 16'h0F5A; in_valid = 1;
    cyc(1);
    in_valid = 0;
    check("pair held", in_ready, 0);
    ur0 = d_ur;
    wait_fall(1, "pair load");
    cyc(1);
    check("pair no underrun", d_ur - ur0, 0);
    check("pair ready again", in_ready, 1);
    rx_q.delete();
    wait_fall(1, "pair done");
    cyc(1);
    check("pair frame", q0(), 64'hA5F0_0F5A);

    // Streaming source: one accept per frame, no gaps
    rx_q.delete();
    acc0 = d_acc; ur0 = d_ur; nxt = 0; last = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (last) nxt++;
      in_left = 16'h1000 + 16'(nxt); in_right = 16'h2000 + 16'(nxt); in_valid = 1;
      last = in_ready;
    end
    in_valid = 0;
    cyc(1);
    check("stream accepts", d_acc - acc0, 3);
    wait_fall(1, "stream drain");
    cyc(1);
    check("stream no underrun", d_ur - ur0, 0);
    check("stream frames", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("stream f0", rx_q[0], 0);
      check("stream f1", rx_q[1], 32'h1000_2000);
      check("stream f2", rx_q[2], 32'h1001_2001);
    end

    // Pair arriving on the very load clock
    wait_pre_load("late pair");
    in_left = 16'h1234; in_right = 16'h5678; in_valid = 1;
    cyc(1);
    in_valid = 0;
    check("late underrun", underrun, 1);
    check("late held", in_ready, 0);
    rx_q.delete();
    wait_fall(1, "late next");
    cyc(1);
    check("late zero frame", q0(), 0);
    rx_q.delete();
    wait_fall(1, "late done");
    cyc(1);
    check("late frame", q0(), 64'h1234_5678);

    // Enable drop mid-frame keeps the held pair
    in_left = 16'hCAFE; in_right = 16'hBEEF; in_valid = 1;
    cyc(1);
    in_valid = 0;
    wait_fall(10, "en slot10");
    en = 0;
    cyc(1);
    check("en0 bclk", bclk, 0);
    check("en0 lrck", lrck, 0);
    check("en0 sdata", sdata, 0);
    check("en0 held", in_ready, 0);
    cyc(19);
    check("en0 still held", in_ready, 0);
    ur0 = d_ur;
    en = 1;
    rx_q.delete();
    wait_fall(1, "restart load");
    cyc(1);
    check("restart no underrun", d_ur - ur0, 0);
    check("restart ready", in_ready, 1);
    wait_fall(1, "restart done");
    cyc(1);
    check("restart frame", q0(), 64'hCAFE_BEEF);

    // Async reset mid-frame discards the held pair
    in_left = 16'h1111; in_right = 16'h2222; in_valid = 1;
    cyc(1);
    in_valid = 0;
    wait_fall(20, "rst slot20");
    cyc(D);
    check("pre-rst bclk", bclk, 1);
    check("pre-rst lrck", lrck, 1);
    check("pre-rst held", in_ready, 0);
    #1 rst = 1;
    #1;
    check("arst bclk", bclk, 0);
    check("arst lrck", lrck, 0);
    check("arst sdata", sdata, 0);
    check("arst underrun", underrun, 0);
    check("arst in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    ur0 = d_ur;
    rx_q.delete();
    wait_fall(1, "post-rst load");
    check("post-rst underrun", underrun, 1);
    wait_fall(1, "post-rst done");
    cyc(1);
    check("post-rst frame", q0(), 0);
    check("post-rst underruns", d_ur - ur0, 2);

    cyc(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
